avalon_read_master: RTL
=======================

Name: avalon_read_master

Overview:
- Avalon-MM read master that serves the rmst_* control and user ports of the layer memory wrappers (e.g. the softmax dual-port memory).
- Accepts a base/length/go command and issues pipelined single-beat XDW-bit reads on the system bus.
- Buffers returned data in a show-ahead FIFO; the user side pops it with read_buffer.
- Pulses done once every requested word has been delivered to the user side.

Parameters:
- XAW, 32, byte address width of the system bus and of the length field.
- XDW, 128, data width of the system bus and FIFO.
- FIFO_DEPTH, 32, number of XDW words in the FIFO; power of two.
- FIFO_AW, 5, log2(FIFO_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- control_fixed_location  in  1  1 = every read uses read_base; 0 = address increments
- control_read_base  in  XAW  byte address of the first word; XDW/8 aligned
- control_read_length  in  XAW  byte count; multiple of XDW/8
- control_go  in  1  one-cycle start pulse
- control_done  out  1  one-cycle pulse when the transfer is complete
- user_read_buffer  in  1  pop the FIFO head
- user_buffer_data  out  XDW  FIFO head word (show-ahead)
- user_data_available  out  1  FIFO not empty
- master_address  out  XAW  Avalon byte address
- master_read  out  1  Avalon read request
- master_byteenable  out  XDW/8  tied to all ones
- master_readdata  in  XDW  Avalon read data
- master_readdatavalid  in  1  Avalon read data valid
- master_waitrequest  in  1  Avalon stall

Behaviour:
- Reset value 0 for all outputs except master_byteenable, which is all ones. Reset clears the FIFO, all counters and the FSM. Reset asserted mid-transfer abandons the transfer: no done pulse, and late readdatavalid beats after reset are dropped.
- FSM states are IDLE, READ and DRAIN.
- IDLE, on control_go:
  - latch addr = read_base, remaining = read_length / (XDW/8), outstanding = 0;
  - latch fixed_location;
  - go to READ, or to DRAIN if remaining == 0.
  - control_go outside IDLE is ignored.
- READ, request issue:
  - master_read is asserted in the cycle after go at the earliest.
  - master_read = 1 while remaining > 0 and fifo_count + outstanding < FIFO_DEPTH.
  - master_address and master_read are held stable while waitrequest = 1.
  - A read is accepted in a cycle where master_read = 1 and waitrequest = 0. On acceptance:
    - remaining decrements;
    - outstanding increments;
    - addr += XDW/8, unless fixed_location is set.
  - The address wraps modulo 2^XAW.
  - When remaining reaches 0 the FSM goes to DRAIN.
- Outstanding accounting:
  - readdatavalid pushes master_readdata into the FIFO and decrements outstanding.
  - A simultaneous accept and readdatavalid leaves outstanding unchanged.
  - The room check guarantees the FIFO never overflows. A push while full is a design error; the verification engineer asserts it never happens.
- DRAIN: when outstanding == 0 and the FIFO is empty, pulse control_done for 1 cycle and return to IDLE. A zero-length transfer gives done 2 cycles after go.
- FIFO behaviour:
  - Show-ahead: user_buffer_data is valid combinationally whenever user_data_available = 1.
  - Push-to-available latency is 1 cycle.
  - Pop while empty is ignored.
  - Push and pop in the same cycle leave the count unchanged, including when the FIFO is full at the start of the cycle.
  - Data order is strictly preserved.
- Widths: remaining and outstanding are XAW bits; fifo_count is FIFO_AW+1 bits. The low log2(XDW/8) bits of length are ignored (truncated).

Decomposition:
- Package rd_master_pkg holds:
  - the FSM state typedef (IDLE, READ, DRAIN);
  - localparam BYTES_PER_WORD = XDW/8;
  - localparam WORD_SHIFT = log2(BYTES_PER_WORD).
- Sub-module rd_master_fifo: synchronous show-ahead FIFO with push, pop, data_in, data_out, empty, full and count, parameterised by XDW and FIFO_AW.

Test Plan:
- Basic transfer: base = 0x1000, length = 64, no waitrequest, readdatavalid 2 cycles after accept.
  - Addresses issued are 0x1000, 0x1010, 0x1020, 0x1030; exactly 4 reads.
  - The 4 words pop in order with user_read_buffer held 1.
  - done pulses once, after the 4th pop.
- Backpressure: waitrequest high for 3 cycles on the 2nd request. master_address stays 0x1010 and master_read stays 1 throughout; no duplicate or skipped address.
- FIFO full: length = 48 words with user_read_buffer = 0.
  - master_read drops when fifo_count + outstanding = 32; no overflow.
  - Popping resumes issue; all 48 words arrive in order.
- Fixed location: fixed_location = 1, base = 0x2000, length = 32. Both reads go to 0x2000; done pulses after 2 pops.
- Edge cases:
  - length = 0 gives no master_read and done 2 cycles after go.
  - go during READ is ignored (address sequence unchanged).
- Reset mid-transfer: async rst after 2 of 8 reads.
  - All outputs are 0 immediately and user_data_available = 0.
  - A later go with base = 0x3000 starts cleanly at 0x3000.

Source files
------------

// File: rtl/rd_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rd_master_pkg
// Description : Shared types and constants for the Avalon-MM read master.
// Revision    : 1.0 - initial release
// ============================================================================
package rd_master_pkg;

    localparam int DEFAULT_XDW    = 128;
    localparam int BYTES_PER_WORD = DEFAULT_XDW / 8;
    localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Byte-to-word shift for an arbitrary bus width.
    function automatic int word_shift(input int xdw);
        return $clog2(xdw / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_master_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rd_master_fifo
// Description : Show-ahead FIFO; head word is visible whenever not empty.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_master_fifo #(
    parameter int XDW     = 128,
    parameter int FIFO_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [XDW-1:0]     data_in,
    output logic [XDW-1:0]     data_out,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   count
);

    localparam int               c_depth      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_full_count = (FIFO_AW + 1)'(c_depth);
    localparam logic [FIFO_AW:0] c_count_one  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] c_ptr_one  = FIFO_AW'(1);

    logic [XDW-1:0]     r_mem [c_depth];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_empty;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_count);
    assign w_do_pop  = pop & ~w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push & (~w_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= data_in;
    end

    assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/avalon_read_master.sv
`default_nettype none
// ============================================================================
// Module      : avalon_read_master
// Description : Pipelined Avalon-MM read master feeding a show-ahead FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_read_master
    import rd_master_pkg::*;
#(
    parameter int XAW        = 32,
    parameter int XDW        = 128,
    parameter int FIFO_DEPTH = 32,
    parameter int FIFO_AW    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               control_fixed_location,
    input  logic [XAW-1:0]     control_read_base,
    input  logic [XAW-1:0]     control_read_length,
    input  logic               control_go,
    output logic               control_done,
    input  logic               user_read_buffer,
    output logic [XDW-1:0]     user_buffer_data,
    output logic               user_data_available,
    output logic [XAW-1:0]     master_address,
    output logic               master_read,
    output logic [XDW/8-1:0]   master_byteenable,
    input  logic [XDW-1:0]     master_readdata,
    input  logic               master_readdatavalid,
    input  logic               master_waitrequest
);

    localparam int             c_word_shift = word_shift(XDW);
    localparam logic [XAW-1:0] c_addr_step  = XAW'(XDW / 8);
    localparam logic [XAW-1:0] c_one        = XAW'(1);
    localparam logic [XAW:0]   c_depth      = (XAW + 1)'(FIFO_DEPTH);

    rd_state_t        r_state;
    rd_state_t        w_state_next;
    logic [XAW-1:0]   r_addr;
    logic [XAW-1:0]   r_remaining;
    logic [XAW-1:0]   r_outstanding;
    logic             r_fixed;
    logic             r_done;

    logic [XAW-1:0]   w_length_words;
    logic [FIFO_AW:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_unused_fifo_full;
    logic [XAW:0]     w_inflight;
    logic             w_read;
    logic             w_accept;
    logic             w_beat;
    logic             w_go;
    logic             w_drained;

    assign w_length_words = control_read_length >> c_word_shift;

    // Words already buffered plus words in flight must fit in the FIFO.
    assign w_inflight = {{(XAW - FIFO_AW){1'b0}}, w_fifo_count} + {1'b0, r_outstanding};
    assign w_read     = (r_state == READ) && (r_remaining != '0) && (w_inflight < c_depth);
    assign w_accept   = w_read && !master_waitrequest;
    // Beats with nothing outstanding belong to an abandoned transfer.
    assign w_beat     = master_readdatavalid && (r_state != IDLE) && (r_outstanding != '0);
    assign w_go       = control_go && (r_state == IDLE);
    assign w_drained  = (r_state == DRAIN) && (r_outstanding == '0) && w_fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (control_go) w_state_next = (w_length_words == '0) ? DRAIN : READ;
            end
            READ: begin
                if (w_accept && (r_remaining == c_one)) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (w_drained) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_fixed       <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= w_drained;
            if (w_go) begin
                r_addr        <= control_read_base;
                r_remaining   <= w_length_words;
                r_outstanding <= '0;
                r_fixed       <= control_fixed_location;
            end else begin
                if (w_accept) begin
                    r_remaining <= r_remaining - c_one;
                    if (!r_fixed) r_addr <= r_addr + c_addr_step;
                end
                case ({w_accept, w_beat})
                    2'b10:   r_outstanding <= r_outstanding + c_one;
                    2'b01:   r_outstanding <= r_outstanding - c_one;
                    default: r_outstanding <= r_outstanding;
                endcase
            end
        end
    end

    rd_master_fifo #(
        .XDW     (XDW),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_beat),
        .pop      (user_read_buffer),
        .data_in  (master_readdata),
        .data_out (user_buffer_data),
        .empty    (w_fifo_empty),
        .full     (w_unused_fifo_full),
        .count    (w_fifo_count)
    );

    assign user_data_available = !w_fifo_empty;
    assign control_done        = r_done;
    assign master_address      = r_addr;
    assign master_read         = w_read;
    assign master_byteenable   = '1;

endmodule
`default_nettype wire
